// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
//
// Purpose:
//   Iterative multiply/divide unit for the EX stage of a 5-stage MIPS
//   pipeline. It executes MULT/MULTU/DIV/DIVU, holds the architectural HI/LO
//   registers, and raises Busy so the hazard unit stalls MFHI/MFLO and any
//   later mult/div op until the result has been written back.
//
//   Multiplication is radix-2 shift-add on operand magnitudes. Division is
//   restoring division on magnitudes. Signs are applied in a final FIX cycle.
//   Iterative latency: Start sampled at E0, WIDTH step cycles, writeback at
//   E(WIDTH+1). Busy is high for WIDTH+1 cycles, then Done pulses for one cycle.
//
// Optional feature (macro MULDIV_FAST_MULT_EN):
//   When defined, MULT/MULTU use a single-cycle multiplier: E0 latch,
//   E1 product and go to FIX, E2 writeback (Busy high for 2 cycles).
//   DIV/DIVU timing is unchanged. When undefined, every op is iterative.
//
// Ports:
//   Clk        pipeline clock; all state updates on the rising edge
//   Reset      synchronous, active-low
//   Start      one-cycle issue strobe for a mult/div op (ignored while Busy)
//   Op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start
//   A, B       rs / rt operands
//   MTHI/MTLO  write WrData to HI/LO when idle and Start is low
//   WrData     data for MTHI/MTLO
//   Busy       operation in progress (stall request)
//   Done       one-cycle pulse once HI/LO hold the new result
//   DivByZero  one-cycle pulse alongside Done when a divide had B==0
//   HI, LO     architectural HI/LO registers
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MTHI,
  input  logic             MTLO,
  input  logic [WIDTH-1:0] WrData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

`ifdef MULDIV_FAST_MULT_EN
  localparam bit FAST_MULT = 1'b1;
`else
  localparam bit FAST_MULT = 1'b0;
`endif

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               is_div_reg;
  logic               neg_q_reg;     // negate product (mult) or quotient (div)
  logic               neg_r_reg;     // negate remainder (div: sign of A)
  logic               div_zero_reg;
  logic [WIDTH-1:0]   operand_reg;   // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   acc_hi_reg;    // product high half / partial remainder
  logic [WIDTH-1:0]   acc_lo_reg;    // multiplier bits / dividend-quotient bits

  // Operand magnitudes and sign flags; only the signed ops (Op[0]==0) look at signs.
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  assign a_neg = ~Op[0] & A[WIDTH-1];
  assign b_neg = ~Op[0] & B[WIDTH-1];
  assign mag_a = a_neg ? (~A + 1'b1) : A;
  assign mag_b = b_neg ? (~B + 1'b1) : B;

  // Shift-add step: add multiplicand when the current multiplier LSB is set,
  // then shift the {hi, lo} pair right by one (carry enters hi's MSB).
  logic [WIDTH:0]     mul_sum;
  assign mul_sum = {1'b0, acc_hi_reg} + {1'b0, ({WIDTH{acc_lo_reg[0]}} & operand_reg)};

  // Restoring step: a clear MSB on the trial difference means it fits.
  logic [WIDTH:0]     div_trial;
  assign div_trial = {acc_hi_reg, acc_lo_reg[WIDTH-1]} - {1'b0, operand_reg};

  // Single-cycle product, only selected when the fast-multiply build is enabled.
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, operand_reg} * {{WIDTH{1'b0}}, acc_lo_reg};

  // Writeback candidates.
  logic [2*WIDTH-1:0] prod_abs;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_abs = {acc_hi_reg, acc_lo_reg};
  assign prod_neg = ~prod_abs + 1'b1;
  assign quo_fix  = neg_q_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
  assign rem_fix  = neg_r_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      operand_reg  <= '0;
      acc_hi_reg   <= '0;
      acc_lo_reg   <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      DivByZero    <= 1'b0;
      HI           <= '0;
      LO           <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            // Start takes priority over a simultaneous move.
            state_reg    <= RUN;
            count_reg    <= '0;
            Busy         <= 1'b1;
            is_div_reg   <= Op[1];
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            div_zero_reg <= Op[1] & (B == '0);
            acc_hi_reg   <= '0;
            // Mult: acc_lo holds the multiplier; div: acc_lo holds the dividend.
            operand_reg  <= Op[1] ? mag_b : mag_a;
            acc_lo_reg   <= Op[1] ? mag_a : mag_b;
          end else begin
            if (MTHI) HI <= WrData;
            if (MTLO) LO <= WrData;
          end
        end

        RUN: begin
          if (FAST_MULT && !is_div_reg) begin
            {acc_hi_reg, acc_lo_reg} <= fast_prod;
            state_reg                <= FIX;
          end else begin
            if (is_div_reg) begin
              if (!div_trial[WIDTH]) begin
                acc_hi_reg <= div_trial[WIDTH-1:0];
                acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b1};
              end else begin
                acc_hi_reg <= {acc_hi_reg[WIDTH-2:0], acc_lo_reg[WIDTH-1]};
                acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc_hi_reg <= mul_sum[WIDTH:1];
              acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
            end
            count_reg <= count_reg + 1'b1;
            if (count_reg == CNT_W'(WIDTH - 1)) state_reg <= FIX;
          end
        end

        FIX: begin
          if (is_div_reg) begin
            // A zero divisor leaves all-ones in the quotient; keep it un-negated.
            LO <= div_zero_reg ? {WIDTH{1'b1}} : quo_fix;
            HI <= rem_fix;
          end else begin
            {HI, LO} <= neg_q_reg ? prod_neg : prod_abs;
          end
          state_reg <= IDLE;
          Busy      <= 1'b0;
          Done      <= 1'b1;
          DivByZero <= div_zero_reg;
        end

        default: begin
          state_reg <= IDLE;
          Busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
//
// Directed testbench for ex_muldiv_unit (WIDTH=32). Each scenario task drives
// its own stimulus and compares against hand-computed values. Honours
// MULDIV_FAST_MULT_EN for the expected multiply latency.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_BUSY = 2;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        MTHI;
  logic        MTLO;
  logic [31:0] WrData;
  logic        Busy;
  logic        Done;
  logic        DivByZero;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int fails  = 0;
  int busy_cyc;
  int overlap;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .MTHI      (MTHI),
    .MTLO      (MTLO),
    .WrData    (WrData),
    .Busy      (Busy),
    .Done      (Done),
    .DivByZero (DivByZero),
    .HI        (HI),
    .LO        (LO)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // All tasks begin and end at a falling edge, where outputs are sampled.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
    busy_cyc = 0;
    overlap  = 0;
  endtask

  task automatic tick();
    if (Busy) busy_cyc++;
    if (Busy && (Done || DivByZero)) overlap++;
    @(negedge Clk);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (Busy && guard < 200) begin
      tick();
      guard++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", Busy); end
    checks++;
    if (Done !== 1'b0) begin fails++; $display("FAIL reset_done got %b expected 0", Done); end
    checks++;
    if (DivByZero !== 1'b0) begin fails++; $display("FAIL reset_dbz got %b expected 0", DivByZero); end
    checks++;
    if (HI !== 32'h0) begin fails++; $display("FAIL reset_hi got %h expected 00000000", HI); end
    checks++;
    if (LO !== 32'h0) begin fails++; $display("FAIL reset_lo got %h expected 00000000", LO); end
    checks++;
    $display("txn reset: busy=%b done=%b hi=%h lo=%h", Busy, Done, HI, LO);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_multiply();
    logic [1:0]  t_op [5];
    logic [31:0] t_a  [5];
    logic [31:0] t_b  [5];
    logic [31:0] t_hi [5];
    logic [31:0] t_lo [5];
    t_op = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
    t_a  = '{32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000, 32'h00012345, 32'h00000007};
    t_b  = '{32'hFFFFFFFF, 32'h00000006, 32'h80000000, 32'h00010000, 32'hFFFFFFFA};
    t_hi = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'h00000001, 32'hFFFFFFFF};
    t_lo = '{32'h00000001, 32'hFFFFFFD6, 32'h00000000, 32'h23450000, 32'hFFFFFFD6};
    for (int i = 0; i < 5; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done();
      $display("txn mul%0d op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d done=%b",
               i, t_op[i], t_a[i], t_b[i], HI, LO, busy_cyc, Done);
      if (busy_cyc !== MUL_BUSY) begin fails++; $display("FAIL mul%0d_busy_cycles got %0d expected %0d", i, busy_cyc, MUL_BUSY); end
      checks++;
      if (Done !== 1'b1) begin fails++; $display("FAIL mul%0d_done got %b expected 1", i, Done); end
      checks++;
      if (DivByZero !== 1'b0) begin fails++; $display("FAIL mul%0d_dbz got %b expected 0", i, DivByZero); end
      checks++;
      if (HI !== t_hi[i]) begin fails++; $display("FAIL mul%0d_hi got %h expected %h", i, HI, t_hi[i]); end
      checks++;
      if (LO !== t_lo[i]) begin fails++; $display("FAIL mul%0d_lo got %h expected %h", i, LO, t_lo[i]); end
      checks++;
      if (overlap !== 0) begin fails++; $display("FAIL mul%0d_pulse_while_busy got %0d expected 0", i, overlap); end
      checks++;
      @(negedge Clk);
      if (Done !== 1'b0) begin fails++; $display("FAIL mul%0d_done_pulse got %b expected 0", i, Done); end
      checks++;
    end
  endtask

  task automatic test_divide();
    logic [1:0]  t_op  [8];
    logic [31:0] t_a   [8];
    logic [31:0] t_b   [8];
    logic [31:0] t_hi  [8];
    logic [31:0] t_lo  [8];
    logic        t_dbz [8];
    t_op  = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11};
    t_a   = '{32'hFFFFFFEF, 32'h00000064, 32'h00000011, 32'hFFFFFFFF,
              32'h80000000, 32'h00001234, 32'hFFFFFFFB, 32'h00000003};
    t_b   = '{32'h00000005, 32'h00000007, 32'hFFFFFFFB, 32'h00000010,
              32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'h00000007};
    t_lo  = '{32'hFFFFFFFD, 32'h0000000E, 32'hFFFFFFFD, 32'h0FFFFFFF,
              32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    t_hi  = '{32'hFFFFFFFE, 32'h00000002, 32'h00000002, 32'h0000000F,
              32'h00000000, 32'h00001234, 32'hFFFFFFFB, 32'h00000003};
    t_dbz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      issue(t_op[i], t_a[i], t_b[i]);
      wait_done();
      $display("txn div%0d op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d done=%b dbz=%b",
               i, t_op[i], t_a[i], t_b[i], HI, LO, busy_cyc, Done, DivByZero);
      if (busy_cyc !== DIV_BUSY) begin fails++; $display("FAIL div%0d_busy_cycles got %0d expected %0d", i, busy_cyc, DIV_BUSY); end
      checks++;
      if (Done !== 1'b1) begin fails++; $display("FAIL div%0d_done got %b expected 1", i, Done); end
      checks++;
      if (DivByZero !== t_dbz[i]) begin fails++; $display("FAIL div%0d_dbz got %b expected %b", i, DivByZero, t_dbz[i]); end
      checks++;
      if (HI !== t_hi[i]) begin fails++; $display("FAIL div%0d_hi got %h expected %h", i, HI, t_hi[i]); end
      checks++;
      if (LO !== t_lo[i]) begin fails++; $display("FAIL div%0d_lo got %h expected %h", i, LO, t_lo[i]); end
      checks++;
      if (overlap !== 0) begin fails++; $display("FAIL div%0d_pulse_while_busy got %0d expected 0", i, overlap); end
      checks++;
      @(negedge Clk);
      if ((Done !== 1'b0) || (DivByZero !== 1'b0)) begin
        fails++; $display("FAIL div%0d_pulse_len got done=%b dbz=%b expected 0 0", i, Done, DivByZero);
      end
      checks++;
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] lo_before;
    lo_before = LO;
    MTHI = 1'b1; WrData = 32'h000000AA;
    @(negedge Clk);
    MTHI = 1'b0;
    $display("txn mthi wr=000000aa -> hi=%h lo=%h", HI, LO);
    if (HI !== 32'h000000AA) begin fails++; $display("FAIL mthi_hi got %h expected 000000aa", HI); end
    checks++;
    if (LO !== lo_before) begin fails++; $display("FAIL mthi_lo_kept got %h expected %h", LO, lo_before); end
    checks++;
    MTLO = 1'b1; WrData = 32'h00000055;
    @(negedge Clk);
    MTLO = 1'b0;
    $display("txn mtlo wr=00000055 -> hi=%h lo=%h", HI, LO);
    if (LO !== 32'h00000055) begin fails++; $display("FAIL mtlo_lo got %h expected 00000055", LO); end
    checks++;
    if (HI !== 32'h000000AA) begin fails++; $display("FAIL mtlo_hi_kept got %h expected 000000aa", HI); end
    checks++;
    MTHI = 1'b1; MTLO = 1'b1; WrData = 32'h00001357;
    @(negedge Clk);
    MTHI = 1'b0; MTLO = 1'b0;
    $display("txn mthi+mtlo wr=00001357 -> hi=%h lo=%h", HI, LO);
    if ({HI, LO} !== {32'h00001357, 32'h00001357}) begin
      fails++; $display("FAIL mt_both got hi=%h lo=%h expected 00001357 00001357", HI, LO);
    end
    checks++;
  endtask

  task automatic test_start_and_move();
    MTHI = 1'b1; WrData = 32'h00000099;
    issue(2'b01, 32'h00000003, 32'h00000005);
    MTHI = 1'b0;
    if (HI !== 32'h00001357) begin fails++; $display("FAIL start_move_dropped got %h expected 00001357", HI); end
    checks++;
    wait_done();
    $display("txn multu+mthi a=3 b=5 -> hi=%h lo=%h busy=%0d", HI, LO, busy_cyc);
    if ({HI, LO} !== {32'h0, 32'h0000000F}) begin
      fails++; $display("FAIL start_move_result got hi=%h lo=%h expected 00000000 0000000f", HI, LO);
    end
    checks++;
    if (busy_cyc !== MUL_BUSY) begin fails++; $display("FAIL start_move_busy got %0d expected %0d", busy_cyc, MUL_BUSY); end
    checks++;
    @(negedge Clk);
  endtask

  task automatic test_move_while_busy();
    issue(2'b11, 32'h00000064, 32'h00000007);
    repeat (3) tick();
    MTLO = 1'b1; MTHI = 1'b1; WrData = 32'h0000DEAD;
    tick();
    MTLO = 1'b0; MTHI = 1'b0;
    if (LO !== 32'h0000000F) begin fails++; $display("FAIL mtlo_busy_lo got %h expected 0000000f", LO); end
    checks++;
    wait_done();
    $display("txn divu+mtlo a=64 b=7 -> hi=%h lo=%h busy=%0d", HI, LO, busy_cyc);
    if ({HI, LO} !== {32'h00000002, 32'h0000000E}) begin
      fails++; $display("FAIL mtlo_busy_result got hi=%h lo=%h expected 00000002 0000000e", HI, LO);
    end
    checks++;
    @(negedge Clk);
  endtask

  task automatic test_start_while_busy();
    issue(2'b11, 32'h000003E8, 32'h00000003);
    repeat (5) tick();
    Start = 1'b1; Op = 2'b01; A = 32'h2; B = 32'h2;
    tick();
    Start = 1'b0;
    wait_done();
    $display("txn divu+restart a=3e8 b=3 -> hi=%h lo=%h busy=%0d done=%b", HI, LO, busy_cyc, Done);
    if (busy_cyc !== DIV_BUSY) begin fails++; $display("FAIL restart_busy got %0d expected %0d", busy_cyc, DIV_BUSY); end
    checks++;
    if (Done !== 1'b1) begin fails++; $display("FAIL restart_done got %b expected 1", Done); end
    checks++;
    if ({HI, LO} !== {32'h00000001, 32'h0000014D}) begin
      fails++; $display("FAIL restart_result got hi=%h lo=%h expected 00000001 0000014d", HI, LO);
    end
    checks++;
    @(negedge Clk);
    if (Busy !== 1'b0) begin fails++; $display("FAIL restart_not_queued got busy=%b expected 0", Busy); end
    checks++;
  endtask

  task automatic test_reset_mid_op();
    logic done_seen;
    issue(2'b10, 32'hFFFFFFEF, 32'h00000005);
    repeat (10) tick();
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    $display("txn div reset@10 -> busy=%b hi=%h lo=%h", Busy, HI, LO);
    if (Busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b expected 0", Busy); end
    checks++;
    if ({HI, LO} !== 64'h0) begin fails++; $display("FAIL midreset_hilo got hi=%h lo=%h expected 0 0", HI, LO); end
    checks++;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      done_seen = done_seen | Done | Busy;
      @(negedge Clk);
    end
    if (done_seen !== 1'b0) begin fails++; $display("FAIL midreset_no_done got %b expected 0", done_seen); end
    checks++;
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    MTHI = 1'b0; MTLO = 1'b0; WrData = '0;
    test_reset();
    test_multiply();
    test_divide();
    test_mthi_mtlo();
    test_start_and_move();
    test_move_while_busy();
    test_start_while_busy();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Consumes the MULT/MULTU/DIV/DIVU operands and control presented at the ID/EX pipeline register outputs.
- Holds the architectural HI/LO registers.
- Drives Busy into the hazard detection unit so that MFHI/MFLO and later mult/div ops stall until the result is ready.

Parameters:
- WIDTH, 32: operand and HI/LO width. The iteration counter is sized for WIDTH iterations.

Ports:
- Clk  input  1  pipeline clock, all state on rising edge
- Reset  input  1  synchronous, active-low; sampled on rising Clk
- Start  input  1  issue strobe from ID/EX for a mult/div op; one cycle
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start
- A  input  WIDTH  rs operand (multiplicand or dividend)
- B  input  WIDTH  rt operand (multiplier or divisor)
- MTHI  input  1  write WrData to HI
- MTLO  input  1  write WrData to LO
- WrData  input  WIDTH  data for MTHI/MTLO
- Busy  output  1  operation in progress; HDU stall request
- Done  output  1  one-cycle pulse; HI/LO hold the new result
- DivByZero  output  1  one-cycle pulse with Done when a DIV/DIVU had B==0
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

Behaviour:
- Reset (Reset==0 at an edge): state IDLE; HI=LO=0; Busy=Done=DivByZero=0; counter=0. Reset mid-operation abandons the op and leaves HI/LO at 0.
- States:
  - IDLE: accepts Start, MTHI, MTLO.
  - RUN: one shift-add or restoring-subtract step per cycle.
  - FIX: sign correction and HI/LO writeback.
- Latency, with edge E0 sampling Start in IDLE:
  - E0: latch |A|, |B|, sign flags and Op; counter=0; go to RUN. Busy=1 from E0.
  - E1..E32: one iteration each; counter increments. At counter==WIDTH-1 the step completes and the state goes to FIX.
  - E33: write HI/LO; go to IDLE.
  - Busy is 0 and Done is 1 for the cycle after E33. Busy is high for exactly WIDTH+1 cycles.
- Start while Busy: ignored, no effect.
- Start and MTHI/MTLO asserted together in IDLE: Start wins; the move is dropped.
- MTHI/MTLO in IDLE: the target register gets WrData at the next edge.
- MTHI and MTLO together: both registers are written.
- MTHI/MTLO while Busy: ignored.
- Multiply:
  - {HI,LO} = full 2*WIDTH-bit product.
  - MULT is signed: magnitudes are multiplied, then the product is negated in FIX if sign(A)^sign(B).
  - MULTU is unsigned.
- Divide:
  - LO = quotient truncated toward zero; HI = remainder with the sign of A (DIV).
  - DIVU is unsigned.
- Divide by zero (B==0):
  - Full latency still applies.
  - LO = all ones; HI = A for DIVU, or the sign-fixed magnitude for DIV.
  - DivByZero pulses with Done.
- DIV overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000, HI=0, no DivByZero.
- Done and DivByZero are never asserted while Busy==1.

Optional Feature:
- Macro: MULDIV_FAST_MULT_EN.
- Defined:
  - MULT/MULTU compute the product with a single-cycle multiplier.
  - Flow is E0 latch, E1 go to FIX, E2 writeback.
  - Busy is high for 2 cycles; Done is asserted in the cycle after E2.
  - DIV/DIVU timing is unchanged.
- Undefined: all ops use the iterative WIDTH+1-cycle path above.

Test Plan:
- Reset held low for 2 edges mid-DIV at iteration 10 -> HI=LO=0, Busy=0 on the next cycle, no Done ever pulses for that op.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy high 33 cycles, then Done; HI=0xFFFFFFFE, LO=0x00000001. With the macro defined, Busy high 2 cycles, same result.
- MULT A=-7 (0xFFFFFFF9), B=6 -> HI=0xFFFFFFFF, LO=0xFFFFFFD6 (-42).
- DIV A=-17, B=5 -> LO=-3 (0xFFFFFFFD), HI=-2 (0xFFFFFFFE). DIVU A=100, B=7 -> LO=14, HI=2.
- DIVU A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234, DivByZero=1 in the same cycle as Done.
- MTHI WrData=0xAA in IDLE -> HI=0xAA next cycle. MTLO during Busy -> LO unchanged. Start pulsed at iteration 5 -> ignored, and the original result is delivered on schedule.
